// File: rtl/prio_rr_arbiter_if.sv
// Request/grant bundle shared by the requesters (master) and the arbiter (slave).
interface prio_rr_arbiter_if #(
  parameter int N  = 8,
  parameter int IW = 3
);
  logic          en;
  logic [N-1:0]  req;
  logic          rr_mode;
  logic          done;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_idx;
  logic          gnt_valid;
  logic          timeout;

  modport master (
    output en, req, rr_mode, done,
    input  gnt, gnt_idx, gnt_valid, timeout
  );

  modport slave (
    input  en, req, rr_mode, done,
    output gnt, gnt_idx, gnt_valid, timeout
  );
endinterface

// File: rtl/prio_rr_arbiter.sv
// Registered N-way arbiter, fixed-priority (MSB wins) or round-robin, grant held until done.
// Optional forced release after TIMEOUT grant cycles when GNT_TIMEOUT_EN is defined.
module prio_rr_arbiter #(
  parameter int N       = 8,
  parameter int IW      = 3,
  parameter int TIMEOUT = 16
) (
  input logic             clk,
  input logic             rst,
  prio_rr_arbiter_if.slave bus
);

  if (IW != $clog2(N) || N < 2 || N > 32 || TIMEOUT < 2 || TIMEOUT > 255) begin : g_param_check
    $error("prio_rr_arbiter: illegal parameter combination");
  end

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic [N-1:0]  ONE_HOT_LSB = {{(N-1){1'b0}}, 1'b1};
  localparam logic [IW-1:0] LAST_IDX    = IW'(N - 1);

  state_e        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] gnt_idx_q, gnt_idx_d;
  logic          gnt_valid_q, gnt_valid_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] start_s;
  logic [IW-1:0] win_idx_s;
  logic          win_found_s;
  logic          expire_s;
`ifdef GNT_TIMEOUT_EN
  logic [7:0]    hold_cnt_q, hold_cnt_d;
  logic          timeout_q, timeout_d;
`endif

  // Winner search: descend from the start index with wrap; start is N-1 in fixed mode.
  always_comb begin : winner_search
    int j;
    j           = 0;
    win_idx_s   = {IW{1'b0}};
    win_found_s = 1'b0;
    start_s     = bus.rr_mode ? ptr_q : LAST_IDX;
    for (int k = 0; k < N; k++) begin
      j = int'(start_s) - k;
      if (j < 0) begin
        j = j + N;
      end else begin
        j = j;
      end
      if (!win_found_s && bus.req[j]) begin
        win_found_s = 1'b1;
        win_idx_s   = IW'(j);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Next-state and registered-output computation.
  always_comb begin : next_state
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    ptr_d       = ptr_q;
    expire_s    = 1'b0;
`ifdef GNT_TIMEOUT_EN
    hold_cnt_d  = hold_cnt_q;
    timeout_d   = 1'b0;
    expire_s    = (state_q == GRANT) && !bus.done && (hold_cnt_q == 8'(TIMEOUT - 1));
`endif
    case (state_q)
      IDLE: begin
        if (bus.en && win_found_s) begin
          state_d     = GRANT;
          gnt_d       = ONE_HOT_LSB << win_idx_s;
          gnt_idx_d   = win_idx_s;
          gnt_valid_d = 1'b1;
`ifdef GNT_TIMEOUT_EN
          hold_cnt_d  = 8'd0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        // Done wins over an expiry on the same edge, so no timeout pulse then.
        if (bus.done || expire_s) begin
          state_d     = IDLE;
          gnt_d       = {N{1'b0}};
          gnt_idx_d   = {IW{1'b0}};
          gnt_valid_d = 1'b0;
          ptr_d       = (gnt_idx_q == {IW{1'b0}}) ? LAST_IDX : gnt_idx_q - IW'(1);
`ifdef GNT_TIMEOUT_EN
          timeout_d   = expire_s;
`endif
        end else begin
          state_d = GRANT;
`ifdef GNT_TIMEOUT_EN
          hold_cnt_d = hold_cnt_q + 8'd1;
`endif
        end
      end
      default: begin
        state_d     = IDLE;
        gnt_d       = {N{1'b0}};
        gnt_idx_d   = {IW{1'b0}};
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin : regs
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= {N{1'b0}};
      gnt_idx_q   <= {IW{1'b0}};
      gnt_valid_q <= 1'b0;
      ptr_q       <= LAST_IDX;
`ifdef GNT_TIMEOUT_EN
      hold_cnt_q  <= 8'd0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      ptr_q       <= ptr_d;
`ifdef GNT_TIMEOUT_EN
      hold_cnt_q  <= hold_cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = gnt_idx_q;
  assign bus.gnt_valid = gnt_valid_q;
`ifdef GNT_TIMEOUT_EN
  assign bus.timeout   = timeout_q;
`else
  assign bus.timeout   = 1'b0 | expire_s;
`endif

endmodule

// File: tb/tb_prio_rr_arbiter.sv
// Directed self-checking bench for prio_rr_arbiter (N=8); timeout cases run when GNT_TIMEOUT_EN is defined.
module tb_prio_rr_arbiter;
  localparam int N  = 8;
  localparam int IW = 3;
`ifdef GNT_TIMEOUT_EN
  localparam int TO       = 4;
  localparam int HOLD_CYC = 2;
`else
  localparam int TO       = 16;
  localparam int HOLD_CYC = 10;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  prio_rr_arbiter_if #(.N(N), .IW(IW)) bus ();

  prio_rr_arbiter #(.N(N), .IW(IW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".gnt"}, 32'(bus.gnt), 32'h0);
    check({tag, ".valid"}, 32'(bus.gnt_valid), 32'h0);
    check({tag, ".idx"}, 32'(bus.gnt_idx), 32'h0);
  endtask

  task automatic check_grant(input string tag, input int idx);
    check({tag, ".idx"}, 32'(bus.gnt_idx), 32'(idx));
    check({tag, ".gnt"}, 32'(bus.gnt), 32'h1 << idx);
    check({tag, ".valid"}, 32'(bus.gnt_valid), 32'h1);
  endtask

  initial begin
    int exp_seq [4];
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    bus.en      = 1'b0;
    bus.req     = 8'h00;
    bus.rr_mode = 1'b0;
    bus.done    = 1'b0;
    tick();
    tick();
    check_idle("reset");
    check("reset.timeout", 32'(bus.timeout), 32'h0);
    rst = 1'b0;
    tick();

    // Fixed priority basic grant and release
    bus.en  = 1'b1;
    bus.req = 8'b0010_0101;
    tick();
    check_grant("fixed", 5);
    bus.done = 1'b1;
    bus.req  = 8'h00;
    tick();
    bus.done = 1'b0;
    check_idle("fixed.rel");

    // Enable gating
    bus.en  = 1'b0;
    bus.req = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("dis.valid", 32'(bus.gnt_valid), 32'h0);
    end
    bus.en = 1'b1;
    tick();
    check_grant("en", 7);
    bus.done = 1'b1;
    bus.req  = 8'h00;
    tick();
    bus.done = 1'b0;
    check_idle("en.rel");

    // Round-robin from a fresh pointer
    rst = 1'b1;
    #2;
    rst = 1'b0;
    bus.rr_mode = 1'b1;
    bus.req     = 8'b1000_0010;
    exp_seq     = '{7, 1, 7, 1};
    for (int i = 0; i < 4; i++) begin
      tick();
      check_grant("rr", exp_seq[i]);
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
      check_idle("rr.gap");
    end

    // Same requests in fixed mode always pick 7
    bus.rr_mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_grant("fx", 7);
      bus.done = 1'b1;
      if (i == 2) bus.req = 8'h00;
      tick();
      bus.done = 1'b0;
      check_idle("fx.gap");
    end

`ifndef GNT_TIMEOUT_EN
    // Without the timeout feature a grant is held indefinitely
    bus.req = 8'b0000_0001;
    tick();
    check_grant("nodone", 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("nodone.timeout", 32'(bus.timeout), 32'h0);
    end
    check_grant("nodone.held", 0);
    bus.done = 1'b1;
    bus.req  = 8'h00;
    tick();
    bus.done = 1'b0;
    check_idle("nodone.rel");
`endif

    // Grant stays fixed while req, rr_mode and en change
    bus.req = 8'b0000_1000;
    tick();
    check_grant("hold", 3);
    bus.req     = 8'b1111_0000;
    bus.rr_mode = 1'b1;
    bus.en      = 1'b0;
    for (int i = 0; i < HOLD_CYC; i++) begin
      tick();
      check_grant("hold.cyc", 3);
    end
    bus.en   = 1'b1;
    bus.done = 1'b1;
    bus.req  = 8'h00;
    tick();
    bus.done = 1'b0;
    check_idle("hold.rel");

    // done while idle has no effect
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    check_idle("idle.done");
    tick();
    check_idle("idle.done2");

    // Asynchronous reset mid-grant; pointer (2 from the idx 3 grant) returns to 7
    bus.req = 8'b0100_0000;
    tick();
    check_grant("mid", 6);
    #2;
    rst = 1'b1;
    #1;
    check("mid.rst.gnt", 32'(bus.gnt), 32'h0);
    check("mid.rst.valid", 32'(bus.gnt_valid), 32'h0);
    bus.req = 8'h41;
    tick();
    rst = 1'b0;
    tick();
    check_grant("post.rst", 6);
    bus.done = 1'b1;
    bus.req  = 8'h00;
    tick();
    bus.done = 1'b0;
    check_idle("post.rel");

`ifdef GNT_TIMEOUT_EN
    // Forced release after TIMEOUT grant cycles
    bus.rr_mode = 1'b0;
    bus.req     = 8'b0000_0001;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_grant("to.cyc", 0);
      check("to.nopulse", 32'(bus.timeout), 32'h0);
      if (i == 3) bus.req = 8'h00;
    end
    tick();
    check_idle("to.rel");
    check("to.pulse", 32'(bus.timeout), 32'h1);
    tick();
    check("to.pulse.end", 32'(bus.timeout), 32'h0);

    // done coinciding with expiry is a normal release
    bus.req = 8'b0000_0001;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_grant("tod.cyc", 0);
    end
    bus.done = 1'b1;
    bus.req  = 8'h00;
    tick();
    bus.done = 1'b0;
    check_idle("tod.rel");
    check("tod.nopulse", 32'(bus.timeout), 32'h0);
    tick();
    check("tod.nopulse2", 32'(bus.timeout), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
